// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the tiny_yolo window generator: default geometry,
// supported kernel sizes and the FSM state type.
package conv_window_gen_pkg;

  localparam int DATA_WIDTH      = 16;
  localparam int INPUT_DIM       = 4;
  localparam int CONV_KERNEL_DIM = 3;
  localparam int DIM_WIDTH       = 9;
  localparam int MAX_COLS        = 416;

  localparam int unsigned CONV_SIZE_1 = 1;
  localparam int unsigned CONV_SIZE_3 = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Anything that is not a 1x1 kernel is handled as 3x3.
  function automatic int unsigned conv_size_eff(input int unsigned size);
    return (size == CONV_SIZE_1) ? CONV_SIZE_1 : CONV_SIZE_3;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One channel's line buffers plus the shift-window history. Presents the
// window that will exist after the pixel currently on the input.
module conv_window_gen_line_buffer #(
  parameter int DATA_WIDTH      = 16,
  parameter int CONV_KERNEL_DIM = 3,
  parameter int DIM_WIDTH       = 9,
  parameter int MAX_COLS        = 416
) (
  input  logic                                                  clk,
  input  logic                                                  pix_valid,
  input  logic [DIM_WIDTH-1:0]                                  wr_addr,
  input  logic [DIM_WIDTH-1:0]                                  rd_addr,
  input  logic [DATA_WIDTH-1:0]                                 pix,
  output logic [CONV_KERNEL_DIM*CONV_KERNEL_DIM*DATA_WIDTH-1:0] window_next
);

  localparam int K  = CONV_KERNEL_DIM;
  localparam int NB = K - 1;

  // Buffer b's registered read data; b=0 holds the previous row.
  logic [NB*DATA_WIDTH-1:0] rd_flat;
  logic [DATA_WIDTH-1:0]    new_col  [K];
  logic [DATA_WIDTH-1:0]    hist_reg [K][K-1];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_buf
      logic [DATA_WIDTH-1:0] mem [MAX_COLS];
      logic [DATA_WIDTH-1:0] rd_reg;
      logic [DATA_WIDTH-1:0] wr_data;

      if (gi == 0) begin : g_first
        assign wr_data = pix;
      end else begin : g_chain
        assign wr_data = rd_flat[(gi-1)*DATA_WIDTH +: DATA_WIDTH];
      end

      // The read address runs one pixel ahead, so a block-RAM read register
      // already holds column c's old contents when pixel c arrives.
      always_ff @(posedge clk) begin
        if (pix_valid) begin
          mem[wr_addr] <= wr_data;
        end
        rd_reg <= mem[rd_addr];
      end

      assign rd_flat[gi*DATA_WIDTH +: DATA_WIDTH] = rd_reg;
    end

    for (gi = 0; gi < K; gi++) begin : g_col
      if (gi == K - 1) begin : g_pix
        assign new_col[gi] = pix;
      end else begin : g_mem
        assign new_col[gi] = rd_flat[(K-2-gi)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    for (gi = 0; gi < K; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_elem
        if (gj == K - 1) begin : g_right
          assign window_next[(gi*K+gj)*DATA_WIDTH +: DATA_WIDTH] = new_col[gi];
        end else begin : g_hist
          assign window_next[(gi*K+gj)*DATA_WIDTH +: DATA_WIDTH] = hist_reg[gi][gj];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int j = 0; j < K - 1; j++) begin
          hist_reg[r][j] <= window_next[(r*K+j+1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK window generator: raster pixel stream in, one window per
// channel out on a flat bus, registered one cycle after the completing pixel.
module conv_window_gen #(
  parameter int DATA_WIDTH      = conv_window_gen_pkg::DATA_WIDTH,
  parameter int INPUT_DIM       = conv_window_gen_pkg::INPUT_DIM,
  parameter int CONV_KERNEL_DIM = conv_window_gen_pkg::CONV_KERNEL_DIM,
  parameter int DIM_WIDTH       = conv_window_gen_pkg::DIM_WIDTH,
  parameter int MAX_COLS        = conv_window_gen_pkg::MAX_COLS
) (
  input  logic                                                            clk,
  input  logic                                                            reset,
  input  logic [DIM_WIDTH-1:0]                                            max_cols_in,
  input  logic [DIM_WIDTH-1:0]                                            max_rows_in,
  input  logic [DIM_WIDTH-1:0]                                            conv_size_in,
  input  logic [INPUT_DIM*DATA_WIDTH-1:0]                                 pix_in,
  input  logic                                                            pix_valid_in,
  output logic [CONV_KERNEL_DIM*CONV_KERNEL_DIM*INPUT_DIM*DATA_WIDTH-1:0] window_bus_out,
  output logic [INPUT_DIM-1:0]                                            window_bus_valid_out,
  output logic                                                            frame_done_out,
  output logic                                                            busy_out
);
  import conv_window_gen_pkg::*;

  localparam int K      = CONV_KERNEL_DIM;
  localparam int KK     = K * K;
  localparam int CH_W   = KK * DATA_WIDTH;
  localparam int BUS_W  = CH_W * INPUT_DIM;
  localparam int CENTRE = (K / 2) * K + K / 2;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0] EDGE_MIN = DIM_WIDTH'(K - 1);

  state_t               state_reg, state_next;
  logic [DIM_WIDTH-1:0] col_reg, col_next;
  logic [DIM_WIDTH-1:0] row_reg, row_next;
  logic [DIM_WIDTH-1:0] cols_reg, rows_reg;
  logic                 size1_reg;
  logic [DIM_WIDTH-1:0] cols_eff, rows_eff;
  logic                 size1_in, size1_eff;
  logic                 col_last, last_pix, issue;
  logic                 valid_reg, frame_done_reg;
  logic [BUS_W-1:0]     window_bus_reg;
  logic [BUS_W-1:0]     win_next;
  logic [BUS_W-1:0]     win_sel;

  assign size1_in = (conv_size_eff(32'(conv_size_in)) == CONV_SIZE_1);

  // The pixel that starts a frame uses the live configuration; later pixels
  // use the copy latched on that first pixel.
  always_comb begin
    cols_eff  = cols_reg;
    rows_eff  = rows_reg;
    size1_eff = size1_reg;
    if (state_reg == ST_IDLE) begin
      cols_eff  = max_cols_in;
      rows_eff  = max_rows_in;
      size1_eff = size1_in;
    end
  end

  assign col_last = (col_reg == cols_eff - DIM_ONE);
  assign last_pix = col_last && (row_reg == rows_eff - DIM_ONE);
  assign issue    = pix_valid_in &&
                    (size1_eff || (row_reg >= EDGE_MIN && col_reg >= EDGE_MIN));

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    if (pix_valid_in) begin
      if (last_pix) begin
        state_next = ST_IDLE;
        col_next   = '0;
        row_next   = '0;
      end else begin
        state_next = ST_STREAM;
        if (col_last) begin
          col_next = '0;
          row_next = row_reg + DIM_ONE;
        end else begin
          col_next = col_reg + DIM_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols_reg       <= '0;
      rows_reg       <= '0;
      size1_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      window_bus_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && pix_valid_in) begin
        cols_reg  <= max_cols_in;
        rows_reg  <= max_rows_in;
        size1_reg <= size1_in;
      end
      valid_reg      <= issue;
      frame_done_reg <= pix_valid_in && last_pix;
      if (issue) begin
        window_bus_reg <= win_sel;
      end
    end
  end

  genvar gi, ge;
  generate
    for (gi = 0; gi < INPUT_DIM; gi++) begin : g_ch
      conv_window_gen_line_buffer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .CONV_KERNEL_DIM (CONV_KERNEL_DIM),
        .DIM_WIDTH       (DIM_WIDTH),
        .MAX_COLS        (MAX_COLS)
      ) u_line_buffer (
        .clk         (clk),
        .pix_valid   (pix_valid_in),
        .wr_addr     (col_reg),
        .rd_addr     (col_next),
        .pix         (pix_in[gi*DATA_WIDTH +: DATA_WIDTH]),
        .window_next (win_next[gi*CH_W +: CH_W])
      );

      // 1x1 mode: only the centre carries the pixel, the ring is zeroed.
      for (ge = 0; ge < KK; ge++) begin : g_elem
        if (ge == CENTRE) begin : g_centre
          assign win_sel[(gi*KK+ge)*DATA_WIDTH +: DATA_WIDTH] =
            size1_eff ? pix_in[gi*DATA_WIDTH +: DATA_WIDTH]
                      : win_next[(gi*KK+ge)*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_ring
          assign win_sel[(gi*KK+ge)*DATA_WIDTH +: DATA_WIDTH] =
            size1_eff ? '0 : win_next[(gi*KK+ge)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

  assign window_bus_out       = window_bus_reg;
  assign window_bus_valid_out = {INPUT_DIM{valid_reg}};
  assign frame_done_out       = frame_done_reg;
  assign busy_out             = (state_reg == ST_STREAM);

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed ramp frames plus random frames, checked
// against a frame-array window model.
module tb_conv_window_gen;

  localparam int DW    = 16;
  localparam int ND    = 4;
  localparam int K     = 3;
  localparam int DIMW  = 9;
  localparam int BUS_W = K * K * ND * DW;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [DIMW-1:0]     max_cols_in = '0;
  logic [DIMW-1:0]     max_rows_in = '0;
  logic [DIMW-1:0]     conv_size_in = '0;
  logic [ND*DW-1:0]    pix_in = '0;
  logic                pix_valid_in = 1'b0;
  logic [BUS_W-1:0]    window_bus_out;
  logic [ND-1:0]       window_bus_valid_out;
  logic                frame_done_out;
  logic                busy_out;

  conv_window_gen dut (
    .clk                  (clk),
    .reset                (reset),
    .max_cols_in          (max_cols_in),
    .max_rows_in          (max_rows_in),
    .conv_size_in         (conv_size_in),
    .pix_in               (pix_in),
    .pix_valid_in         (pix_valid_in),
    .window_bus_out       (window_bus_out),
    .window_bus_valid_out (window_bus_valid_out),
    .frame_done_out       (frame_done_out),
    .busy_out             (busy_out)
  );

  always #5 clk = ~clk;

  int               err_cnt = 0;
  int               chk_cnt = 0;
  int               win_cnt = 0;
  logic [DW-1:0]    fr [256][ND];
  logic [BUS_W-1:0] hold_bus = '0;

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Window ending at pixel idx, taken straight from the stored frame.
  function automatic logic [BUS_W-1:0] exp_window(input int idx, input int w, input bit s1);
    logic [BUS_W-1:0] b;
    int row, col, e;
    b   = '0;
    row = idx / w;
    col = idx % w;
    for (int ch = 0; ch < ND; ch++) begin
      for (int r = 0; r < K; r++) begin
        for (int cc = 0; cc < K; cc++) begin
          e = r * K + cc;
          if (s1) begin
            if (e == 4) b[(ch*9+e)*DW +: DW] = fr[idx][ch];
          end else begin
            b[(ch*9+e)*DW +: DW] = fr[(row-2+r)*w + (col-2+cc)][ch];
          end
        end
      end
    end
    return b;
  endfunction

  task automatic step(input string tag, input bit exp_valid, input logic [BUS_W-1:0] exp_bus,
                      input bit exp_done, input bit exp_busy);
    @(posedge clk);
    #1;
    chk($sformatf("%s.valid", tag), BUS_W'(window_bus_valid_out), BUS_W'(exp_valid ? 4'hF : 4'h0));
    if (exp_valid) hold_bus = exp_bus;
    chk($sformatf("%s.bus", tag), window_bus_out, hold_bus);
    chk($sformatf("%s.done", tag), BUS_W'(frame_done_out), BUS_W'(exp_done));
    chk($sformatf("%s.busy", tag), BUS_W'(busy_out), BUS_W'(exp_busy));
    if (window_bus_valid_out != '0) win_cnt++;
  endtask

  // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random gaps.
  // base < 0 gives random pixels; stop_after truncates the frame.
  task automatic run_frame(input string tag, input int w, input int h, input int size,
                           input int gap_mode, input int base, input int stop_after);
    int n, lim, gaps, row, col, exp_cnt;
    bit s1, iss, last;
    n       = w * h;
    lim     = (stop_after < n) ? stop_after : n;
    s1      = (size == 1);
    exp_cnt = 0;
    win_cnt = 0;
    for (int idx = 0; idx < n; idx++) begin
      for (int ch = 0; ch < ND; ch++) begin
        fr[idx][ch] = (base < 0) ? DW'($urandom) : DW'(base + idx + 16 * ch);
      end
    end
    for (int idx = 0; idx < lim; idx++) begin
      gaps = 0;
      if (gap_mode == 1) gaps = (idx % 2 == 1) ? 2 : 0;
      if (gap_mode == 2) gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        pix_valid_in = 1'b0;
        pix_in       = {$urandom, $urandom};
        step($sformatf("%s.gap%0d", tag, idx), 1'b0, '0, 1'b0, idx > 0);
      end
      if (idx == 0) begin
        max_cols_in  = DIMW'(w);
        max_rows_in  = DIMW'(h);
        conv_size_in = DIMW'(size);
      end else begin
        max_cols_in  = DIMW'($urandom);
        max_rows_in  = DIMW'($urandom);
        conv_size_in = DIMW'($urandom);
      end
      for (int ch = 0; ch < ND; ch++) pix_in[ch*DW +: DW] = fr[idx][ch];
      pix_valid_in = 1'b1;
      row  = idx / w;
      col  = idx % w;
      iss  = s1 || (row >= 2 && col >= 2);
      last = (idx == n - 1);
      if (iss) exp_cnt++;
      step($sformatf("%s.px%0d", tag, idx), iss, iss ? exp_window(idx, w, s1) : '0, last, !last);
    end
    pix_valid_in = 1'b0;
    if (lim == n) chk($sformatf("%s.count", tag), BUS_W'(win_cnt), BUS_W'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sizes [5];
    int w, h;
    sizes = '{1, 3, 0, 2, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", BUS_W'(window_bus_valid_out), '0);
    chk("reset.bus", window_bus_out, '0);
    chk("reset.done", BUS_W'(frame_done_out), '0);
    chk("reset.busy", BUS_W'(busy_out), '0);
    reset = 1'b1;
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    run_frame("ramp3", 4, 4, 3, 0, 0, 999);
    run_frame("ramp1", 4, 4, 1, 0, 0, 999);
    run_frame("gap3", 4, 4, 3, 1, 0, 999);
    run_frame("b2b_a", 4, 4, 3, 0, 0, 999);
    run_frame("b2b_b", 4, 4, 3, 0, 100, 999);

    run_frame("abort", 4, 4, 3, 0, 0, 8);
    reset = 1'b0;
    #1;
    hold_bus = '0;
    chk("rst_mid.valid", BUS_W'(window_bus_valid_out), '0);
    chk("rst_mid.bus", window_bus_out, '0);
    chk("rst_mid.done", BUS_W'(frame_done_out), '0);
    chk("rst_mid.busy", BUS_W'(busy_out), '0);
    step("rst_hold", 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    run_frame("restart", 4, 4, 3, 0, 0, 999);

    run_frame("degen", 2, 5, 3, 0, 0, 999);

    for (int t = 0; t < 14; t++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 8);
      run_frame($sformatf("rnd%0d", t), w, h, sizes[$urandom_range(0, 4)],
                ($urandom_range(0, 1) == 0) ? 0 : 2, -1, 999);
    end
    step("tail", 1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
